// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register file write port, with a pending-write
// scoreboard that flags read-after-write hazards on the two read addresses.
module rf_write_arbiter #(
  parameter int unsigned F    = 5,
  parameter int unsigned D    = 32,
  parameter int unsigned NREQ = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*F-1:0] req_addr_i,
  input  logic [NREQ*D-1:0] req_data_i,
  input  logic              rsv_valid_i,
  input  logic [F-1:0]      rsv_addr_i,
  input  logic [F-1:0]      ra1_i,
  input  logic [F-1:0]      ra2_i,
  output logic              busy1_o,
  output logic              busy2_o,
  output logic [2**F-1:0]   busy_vec_o,
  output logic              rsv_conflict_o,
  output logic              we3_o,
  output logic [F-1:0]      wa3_o,
  output logic [D-1:0]      wd3_o
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   grant;
  logic [PW-1:0]     grant_idx;
  logic              xfer;
  logic [F-1:0]      sel_addr;
  logic [D-1:0]      sel_data;
  logic              we3_q, we3_d;
  logic [F-1:0]      wa3_q, wa3_d;
  logic [D-1:0]      wd3_q, wd3_d;
  logic [2**F-1:0]   pend_q, pend_d;
  logic              conflict_q, conflict_d;
  logic              rsv_set;

  // First valid at or above the pointer wins; otherwise wrap to the lowest valid.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    xfer      = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!xfer && req_valid_i[i] && (PW'(i) >= rr_ptr_q)) begin
        xfer      = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PW'(i);
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!xfer && req_valid_i[i]) begin
        xfer      = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PW'(i);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        sel_addr = req_addr_i[i*F +: F];
        sel_data = req_data_i[i*D +: D];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  always_comb begin
    we3_d = 1'b0;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (xfer) begin
      we3_d = (sel_addr != '0);
      wa3_d = sel_addr;
      wd3_d = sel_data;
    end
  end

  // Clear is applied first so a same-edge reservation of the same register wins.
  assign rsv_set = rsv_valid_i && (rsv_addr_i != '0);

  always_comb begin
    pend_d = pend_q;
    if (xfer) begin
      pend_d[sel_addr] = 1'b0;
    end
    if (rsv_set) begin
      pend_d[rsv_addr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  assign conflict_d = rsv_set && pend_q[rsv_addr_i];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q   <= '0;
      we3_q      <= 1'b0;
      wa3_q      <= '0;
      wd3_q      <= '0;
      pend_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      we3_q      <= we3_d;
      wa3_q      <= wa3_d;
      wd3_q      <= wd3_d;
      pend_q     <= pend_d;
      conflict_q <= conflict_d;
    end
  end

  assign req_ready_o    = grant;
  assign we3_o          = we3_q;
  assign wa3_o          = wa3_q;
  assign wd3_o          = wd3_q;
  assign busy_vec_o     = pend_q;
  assign busy1_o        = pend_q[ra1_i];
  assign busy2_o        = pend_q[ra2_i];
  assign rsv_conflict_o = conflict_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: handshake, round-robin, write port,
// scoreboard hazards, register-0 handling, conflicts and asynchronous reset.
module tb_rf_write_arbiter;

  localparam int unsigned F    = 5;
  localparam int unsigned D    = 32;
  localparam int unsigned NREQ = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*F-1:0] req_addr;
  logic [NREQ*D-1:0] req_data;
  logic              rsv_valid;
  logic [F-1:0]      rsv_addr;
  logic [F-1:0]      ra1, ra2;
  logic              busy1, busy2;
  logic [2**F-1:0]   busy_vec;
  logic              rsv_conflict;
  logic              we3;
  logic [F-1:0]      wa3;
  logic [D-1:0]      wd3;

  int n_checks = 0;
  int n_fail   = 0;
  int g0_cnt   = 0;
  int g1_cnt   = 0;

  rf_write_arbiter #(.F(F), .D(D), .NREQ(NREQ)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_data_i    (req_data),
    .rsv_valid_i   (rsv_valid),
    .rsv_addr_i    (rsv_addr),
    .ra1_i         (ra1),
    .ra2_i         (ra2),
    .busy1_o       (busy1),
    .busy2_o       (busy2),
    .busy_vec_o    (busy_vec),
    .rsv_conflict_o(rsv_conflict),
    .we3_o         (we3),
    .wa3_o         (wa3),
    .wd3_o         (wd3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    ra1       = '0;
    ra2       = '0;
    #1;
    chk("rst_we3", 64'(we3), 64'd0);
    chk("rst_wa3", 64'(wa3), 64'd0);
    chk("rst_wd3", 64'(wd3), 64'd0);
    chk("rst_busy_vec", 64'(busy_vec), 64'd0);
    chk("rst_conflict", 64'(rsv_conflict), 64'd0);
    chk("rst_ready_idle", 64'(req_ready), 64'd0);
    tick();
    tick();
    reset = 1'b0;

    // Single write from requester 1
    req_valid      = 2'b10;
    req_addr[9:5]  = 5'd5;
    req_data[63:32] = 32'hDEADBEEF;
    #1;
    chk("single_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid = 2'b00;
    chk("single_we3", 64'(we3), 64'd1);
    chk("single_wa3", 64'(wa3), 64'd5);
    chk("single_wd3", 64'(wd3), 64'hDEADBEEF);
    tick();
    chk("single_we3_drop", 64'(we3), 64'd0);
    chk("single_wa3_hold", 64'(wa3), 64'd5);

    // Round-robin with both requesters continuously valid
    req_valid       = 2'b11;
    req_addr[4:0]   = 5'd3;
    req_addr[9:5]   = 5'd4;
    req_data[31:0]  = 32'h000000A0;
    req_data[63:32] = 32'h000000B1;
    #1;
    for (int c = 0; c < 8; c++) begin
      chk("rr_ready", 64'(req_ready), (c % 2 == 0) ? 64'b01 : 64'b10);
      if (req_ready == 2'b01) g0_cnt++;
      if (req_ready == 2'b10) g1_cnt++;
      tick();
      chk("rr_we3", 64'(we3), 64'd1);
      chk("rr_wa3", 64'(wa3), (c % 2 == 0) ? 64'd3 : 64'd4);
    end
    chk("rr_count0", 64'(g0_cnt), 64'd4);
    chk("rr_count1", 64'(g1_cnt), 64'd4);
    req_valid = 2'b00;
    tick();

    // Scoreboard stall on register 9
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    ra1       = 5'd9;
    #1;
    chk("sb_busy1_before", 64'(busy1), 64'd0);
    tick();
    rsv_valid = 1'b0;
    chk("sb_busy1_set", 64'(busy1), 64'd1);
    chk("sb_vec_set", 64'(busy_vec), 64'h200);
    chk("sb_busy2_ra0", 64'(busy2), 64'd0);
    tick();
    chk("sb_busy1_hold", 64'(busy1), 64'd1);
    req_valid      = 2'b01;
    req_addr[4:0]  = 5'd9;
    req_data[31:0] = 32'h00000099;
    #1;
    chk("sb_ready", 64'(req_ready), 64'b01);
    chk("sb_busy1_accept", 64'(busy1), 64'd1);
    tick();
    req_valid = 2'b00;
    chk("sb_we3", 64'(we3), 64'd1);
    chk("sb_wa3", 64'(wa3), 64'd9);
    chk("sb_busy1_clear", 64'(busy1), 64'd0);

    // Register 0 write is accepted but dropped
    rsv_valid = 1'b1;
    rsv_addr  = 5'd12;
    tick();
    rsv_valid = 1'b0;
    chk("r0_vec_pre", 64'(busy_vec), 64'h1000);
    req_valid     = 2'b10;
    req_addr[9:5] = 5'd0;
    #1;
    chk("r0_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid = 2'b00;
    chk("r0_we3", 64'(we3), 64'd0);
    chk("r0_vec", 64'(busy_vec), 64'h1000);

    // Same-edge reserve and write of register 12: reservation wins
    req_valid      = 2'b01;
    req_addr[4:0]  = 5'd12;
    req_data[31:0] = 32'h00000012;
    rsv_valid      = 1'b1;
    rsv_addr       = 5'd12;
    #1;
    chk("sbc_ready", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    rsv_valid = 1'b0;
    chk("sbc_we3", 64'(we3), 64'd1);
    chk("sbc_wa3", 64'(wa3), 64'd12);
    chk("sbc_vec", 64'(busy_vec), 64'h1000);
    req_valid     = 2'b10;
    req_addr[9:5] = 5'd12;
    tick();
    req_valid = 2'b00;
    chk("sbc_vec_clear", 64'(busy_vec), 64'h0);

    // Double reservation of register 6
    rsv_valid = 1'b1;
    rsv_addr  = 5'd6;
    tick();
    chk("cf_first", 64'(rsv_conflict), 64'd0);
    chk("cf_vec1", 64'(busy_vec), 64'h40);
    tick();
    rsv_valid = 1'b0;
    chk("cf_pulse", 64'(rsv_conflict), 64'd1);
    chk("cf_vec2", 64'(busy_vec), 64'h40);
    tick();
    chk("cf_end", 64'(rsv_conflict), 64'd0);
    chk("cf_vec3", 64'(busy_vec), 64'h40);

    // Asynchronous reset mid-stream
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    tick();
    rsv_valid      = 1'b0;
    req_valid      = 2'b01;
    req_addr[4:0]  = 5'd7;
    req_data[31:0] = 32'h00000077;
    chk("mr_vec_pre", 64'(busy_vec), 64'hC0);
    tick();
    chk("mr_we3_pre", 64'(we3), 64'd1);
    chk("mr_wa3_pre", 64'(wa3), 64'd7);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_we3", 64'(we3), 64'd0);
    chk("mr_wa3", 64'(wa3), 64'd0);
    chk("mr_wd3", 64'(wd3), 64'd0);
    chk("mr_vec", 64'(busy_vec), 64'd0);
    tick();
    chk("mr_we3_hold", 64'(we3), 64'd0);
    reset          = 1'b0;
    req_valid      = 2'b11;
    req_addr[9:5]  = 5'd8;
    req_data[63:32] = 32'h00000088;
    #1;
    chk("mr_first_grant", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    chk("mr_post_we3", 64'(we3), 64'd1);
    chk("mr_post_wa3", 64'(wa3), 64'd7);
    chk("mr_post_wd3", 64'(wd3), 64'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port (we3/wa3/wd3) of the processor's register file among NREQ producers, e.g. pipeline writeback and the multi-cycle cipher unit.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered drive of the write port.
- Per-register pending-write scoreboard that reports read-after-write hazards on the two read addresses to the stall logic.

Parameters:
F, 5, register address width; the file holds 2**F registers.
D, 32, data width.
NREQ, 2, number of write requesters; minimum 2.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  NREQ  requester i holds a write.
req_ready  out  NREQ  requester i's write is accepted this cycle.
req_addr  in  NREQ*F  destination address, slice i = bits [i*F +: F].
req_data  in  NREQ*D  write data, slice i = bits [i*D +: D].
rsv_valid  in  1  reserve a destination register at issue.
rsv_addr  in  F  register being reserved.
ra1  in  F  read address 1 for the hazard check.
ra2  in  F  read address 2 for the hazard check.
busy1  out  1  ra1 has a pending write.
busy2  out  1  ra2 has a pending write.
busy_vec  out  2**F  full scoreboard.
rsv_conflict  out  1  one-cycle pulse: a reservation hit an already-pending register.
we3  out  1  register file write enable.
wa3  out  F  register file write address.
wd3  out  D  register file write data.

Behaviour:
- Reset (asynchronous, immediate):
  - we3=0, wa3=0, wd3=0, rsv_conflict=0.
  - All pending bits cleared; round-robin pointer rr_ptr=0.
  - A write accepted before reset but not yet driven is discarded.
- Arbitration (combinational):
  - Scan requesters starting at rr_ptr with wrap-around; the first one with req_valid=1 is granted.
  - req_ready = one-hot grant; at most one bit is set per cycle, and it is all-zero when no requester is valid.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - req_ready is independent of downstream state: the write port accepts one write every cycle.
- Pointer update: on a transfer from requester g, rr_ptr <= (g+1) mod NREQ. With no transfer, rr_ptr holds.
- Requester rule: once req_valid rises, address and data are held stable until accepted. The arbiter does not check this.
- Write port (registered, latency 1):
  - On the posedge that accepts the transfer: we3 <= (addr != 0), wa3 <= addr, wd3 <= data.
  - With no transfer: we3 <= 0; wa3 and wd3 hold their last values.
  - The register file then writes on the following negedge.
- Writes to register 0: the handshake completes normally (ready=1), but we3 stays 0. The write is dropped.
- Scoreboard, pend[r] for r in 0..2**F-1:
  - Set: rsv_valid & rsv_addr!=0 sets pend[rsv_addr] at the posedge.
  - Clear: a transfer to address a clears pend[a] at the same posedge at which we3 rises. Readers in that cycle sample after the negedge write, so no extra stall cycle is needed.
  - Set and clear of the same register on the same edge: set wins. The new reservation belongs to a later producer.
  - Reserving a register with pend=1 already: the bit stays 1 (there is no counter), and rsv_conflict pulses 1 for the next cycle. The protocol allows one outstanding write per register.
  - A transfer to an unreserved register is legal and leaves the scoreboard unchanged.
  - pend[0] is never set.
- Hazard outputs (combinational from registered state):
  - busy1 = pend[ra1]; busy2 = pend[ra2].
  - Both are 0 whenever the corresponding address is 0.
  - busy_vec = pend.

Test Plan:
- Reset sequencing: assert reset mid-stream while req_valid[0]=1 and pend[7]=1 -> we3, wa3, wd3 and busy_vec go to 0 immediately; after release, the first grant goes to requester 0.
- Single write: req_valid[1]=1, addr=5, data=0xDEADBEEF, others idle -> req_ready=2'b10 the same cycle; next cycle we3=1, wa3=5, wd3=0xDEADBEEF; the cycle after, we3=0.
- Round-robin fairness: NREQ=2, both valid continuously with addresses 3 and 4 -> grants alternate 0,1,0,1; each requester gets exactly 4 of 8 consecutive cycles; we3 is high every cycle.
- Scoreboard stall: rsv_valid with rsv_addr=9, ra1=9 -> busy1=1 from the next cycle; busy1 stays 1 until the cycle a write to 9 is accepted, then reads 0 in the cycle we3=1.
- Register 0 and set-beats-clear:
  - Write to address 0 -> ready=1, we3 stays 0, busy_vec unchanged.
  - Same edge: reserve 12 while a write to 12 transfers -> pend[12] stays 1.
- Conflict: reserve 6 twice with no intervening write -> rsv_conflict=1 for exactly one cycle after the second reserve; pend[6]=1.
